// File: rtl/fifo_word_packer_if.sv
// rtl/fifo_word_packer_if.sv - packed-word valid/ready stream between the packer and its consumer.
// m_parity exists only when FIFO_PACK_PARITY_EN is defined.
interface fifo_word_packer_if #(
   parameter int WIDTH = 8,
   parameter int LANES = 4
);
   logic                   m_valid;
   logic                   m_ready;
   logic [WIDTH*LANES-1:0] m_data;
   logic [LANES-1:0]       m_keep;
`ifdef FIFO_PACK_PARITY_EN
   logic [LANES-1:0]       m_parity;
`endif

   modport master (
      input  m_ready,
      output m_valid,
      output m_data,
      output m_keep
`ifdef FIFO_PACK_PARITY_EN
      ,
      output m_parity
`endif
   );

   modport slave (
      output m_ready,
      input  m_valid,
      input  m_data,
      input  m_keep
`ifdef FIFO_PACK_PARITY_EN
      ,
      input  m_parity
`endif
   );
endinterface

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - drains a byte FIFO, packs LANES entries per word, mirrors FIFO occupancy.
// Optional per-lane parity output enabled by FIFO_PACK_PARITY_EN.
module fifo_word_packer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256,
   parameter int LANES = 4,
   parameter int CNT_W = 9
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 push_mon,
   input  logic [WIDTH-1:0]     fifo_dout,
   output logic                 pop,
   input  logic                 flush,
   fifo_word_packer_if.master   m,
   output logic [CNT_W-1:0]     occupancy,
   output logic                 overflow
);
   localparam int                IDX_W = $clog2(LANES + 1);
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(LANES - 1);
   localparam logic [IDX_W-1:0]  NLANE = IDX_W'(LANES);

   typedef enum logic {FILL, HOLD} state_t;

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic                   valid_q;
   logic [WIDTH*LANES-1:0] data_q;
   logic [LANES-1:0]       keep_q;
`ifdef FIFO_PACK_PARITY_EN
   logic [LANES-1:0]       parity_q;
`endif

   assign pop = (state == FILL) && (occupancy != '0) && (idx < NLANE);

   // A push into a full FIFO is dropped by the FIFO, so the mirror holds and flags it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occupancy <= '0;
         overflow  <= 1'b0;
      end else if (push_mon && !pop) begin
         if (occupancy == FULL)
            overflow <= 1'b1;
         else
            occupancy <= occupancy + 1'b1;
      end else if (!push_mon && pop) begin
         occupancy <= occupancy - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= FILL;
         idx     <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
`ifdef FIFO_PACK_PARITY_EN
         parity_q <= '0;
`endif
      end else begin
         case (state)
            FILL: begin
               if (pop) begin
                  for (int i = 0; i < LANES; i++) begin
                     if (idx == IDX_W'(i)) begin
                        data_q[i*WIDTH +: WIDTH] <= fifo_dout;
                        keep_q[i]                <= 1'b1;
`ifdef FIFO_PACK_PARITY_EN
                        parity_q[i]              <= ^fifo_dout;
`endif
                     end
                  end
                  idx <= idx + 1'b1;
                  if (idx == LAST) begin
                     state   <= HOLD;
                     valid_q <= 1'b1;
                  end
               end else if (flush && (occupancy == '0) && (idx != '0)) begin
                  // Unfilled lanes are still zero from the previous clear.
                  state   <= HOLD;
                  valid_q <= 1'b1;
               end
            end
            HOLD: begin
               if (m.m_ready) begin
                  state   <= FILL;
                  valid_q <= 1'b0;
                  idx     <= '0;
                  data_q  <= '0;
                  keep_q  <= '0;
`ifdef FIFO_PACK_PARITY_EN
                  parity_q <= '0;
`endif
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign m.m_valid = valid_q;
   assign m.m_data  = data_q;
   assign m.m_keep  = keep_q;
`ifdef FIFO_PACK_PARITY_EN
   assign m.m_parity = parity_q;
`endif
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - self-checking bench for fifo_word_packer with a behavioural byte FIFO.
// Parity scenario compiled in when FIFO_PACK_PARITY_EN is defined.
module tb_fifo_word_packer;
   localparam int WIDTH = 8;
   localparam int DEPTH = 256;
   localparam int LANES = 4;
   localparam int CNT_W = 9;
   localparam int PW    = $clog2(DEPTH);
   localparam int WL    = WIDTH * LANES;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             push_mon = 1'b0;
   logic             flush = 1'b0;
   logic [WIDTH-1:0] push_data = '0;
   logic [WIDTH-1:0] fifo_dout;
   logic             pop;
   logic [CNT_W-1:0] occupancy;
   logic             overflow;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   fifo_word_packer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

   fifo_word_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .push_mon  (push_mon),
      .fifo_dout (fifo_dout),
      .pop       (pop),
      .flush     (flush),
      .m         (bus),
      .occupancy (occupancy),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural byte FIFO: ring buffer plus fill count, dropping pushes when full.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   int               cnt;
   logic             exp_ovf;
   logic             s_push = 1'b0, s_pop = 1'b0;
   logic [WIDTH-1:0] s_data = '0;

   assign fifo_dout = mem[rd_ptr];

   always @(negedge clk) begin
      s_push <= push_mon;
      s_pop  <= pop;
      s_data <= push_data;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= 0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         exp_ovf <= 1'b0;
      end else begin
         if (s_push && (cnt < DEPTH || s_pop)) begin
            mem[wr_ptr] <= s_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (s_push && cnt == DEPTH && !s_pop) exp_ovf <= 1'b1;
         cnt <= cnt + ((s_push && (cnt < DEPTH || s_pop)) ? 1 : 0) - (s_pop ? 1 : 0);
         if (s_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   logic [WL-1:0]    got_data[$];
   logic [LANES-1:0] got_keep[$];
   logic [LANES-1:0] got_par[$];
   int               got_cyc[$];
   logic [WL-1:0]    exp_data[$];
   logic [LANES-1:0] exp_keep[$];
   logic [WIDTH-1:0] sent[$];

   always @(negedge clk) begin
      if (reset_n && bus.m_valid && bus.m_ready) begin
         got_data.push_back(bus.m_data);
         got_keep.push_back(bus.m_keep);
         got_cyc.push_back(cyc);
`ifdef FIFO_PACK_PARITY_EN
         got_par.push_back(bus.m_parity);
`endif
      end
   end

   task automatic clear_queues();
      got_data.delete(); got_keep.delete(); got_par.delete(); got_cyc.delete();
      exp_data.delete(); exp_keep.delete(); sent.delete();
   endtask

   task automatic do_reset();
      reset_n = 1'b0; push_mon = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      clear_queues();
   endtask

   task automatic push_byte(input logic [WIDTH-1:0] b);
      push_mon = 1'b1; push_data = b; sent.push_back(b);
      @(posedge clk); #1;
      push_mon = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Reference grouping: consecutive sent bytes form words, first byte in lane 0.
   task automatic build_expected(input bit with_tail);
      logic [WL-1:0]    w;
      logic [LANES-1:0] k;
      for (int b = 0; b < sent.size(); b += LANES) begin
         w = '0; k = '0;
         for (int j = 0; j < LANES; j++)
            if (b + j < sent.size()) begin
               w[j*WIDTH +: WIDTH] = sent[b+j];
               k[j] = 1'b1;
            end
         if (k == {LANES{1'b1}} || with_tail) begin
            exp_data.push_back(w); exp_keep.push_back(k);
         end
      end
      sent.delete();
   endtask

   task automatic wait_words(input int n, input int budget, output bit ok);
      int t = 0;
      while (got_data.size() < n && t < budget) begin @(posedge clk); #1; t++; end
      ok = (got_data.size() >= n);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; push_mon = 1'b0; flush = 1'b0; bus.m_ready = 1'b0;
      @(posedge clk); #1;
      checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.m_valid); end
      checks++; if (bus.m_keep !== '0) begin failures++; $display("FAIL reset_keep got=%h want=0", bus.m_keep); end
      checks++; if (bus.m_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", bus.m_data); end
      checks++; if (occupancy !== '0) begin failures++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow); end
      checks++; if (pop !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b want=0", pop); end
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      bus.m_ready = 1'b1;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", bus.m_valid); end
      @(posedge clk); #1;
      checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", bus.m_valid); end
      checks++; if (bus.m_data !== 32'h44332211) begin failures++; $display("FAIL basic_data got=%h want=44332211", bus.m_data); end
      checks++; if (bus.m_keep !== 4'hF) begin failures++; $display("FAIL basic_keep got=%h want=f", bus.m_keep); end
      checks++; if (occupancy !== '0) begin failures++; $display("FAIL basic_occ got=%0d want=0", occupancy); end
      idle(1);
      checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL basic_after_hs got=%b want=0", bus.m_valid); end
      checks++; if (got_data.size() != 1) begin failures++; $display("FAIL basic_count got=%0d want=1", got_data.size()); end
   endtask

   task automatic test_flush();
      bit ok;
      int seen = 0;
      do_reset();
      bus.m_ready = 1'b1;
      push_byte(8'hA5); push_byte(8'h5A);
      flush = 1'b1;
      build_expected(1'b1);
      wait_words(1, 20, ok);
      checks++; if (!ok) begin failures++; $display("FAIL flush_timeout got=%0d want=1 words", got_data.size()); end
      if (ok) begin
         checks++; if (got_data[0] !== exp_data[0]) begin failures++; $display("FAIL flush_data got=%h want=%h", got_data[0], exp_data[0]); end
         checks++; if (got_keep[0] !== 4'h3) begin failures++; $display("FAIL flush_keep got=%h want=3", got_keep[0]); end
      end
      repeat (10) begin @(posedge clk); #1; if (bus.m_valid) seen++; end
      checks++; if (seen != 0) begin failures++; $display("FAIL flush_empty_valid got=%0d want=0 cycles", seen); end
      flush = 1'b0;
   endtask

   task automatic test_hold();
      bit ok;
      logic [WL-1:0] first;
      int bad_pop = 0, bad_data = 0;
      do_reset();
      bus.m_ready = 1'b0;
      repeat (8) push_byte(WIDTH'($urandom));
      build_expected(1'b0);
      first = exp_data[0];
      checks++; if (bus.m_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b want=1", bus.m_valid); end
      checks++; if (bus.m_data !== first) begin failures++; $display("FAIL hold_data got=%h want=%h", bus.m_data, first); end
      checks++; if (occupancy !== CNT_W'(4)) begin failures++; $display("FAIL hold_occ got=%0d want=4", occupancy); end
      repeat (5) begin
         @(negedge clk);
         if (pop !== 1'b0) bad_pop++;
         if (bus.m_data !== first || bus.m_keep !== 4'hF) bad_data++;
      end
      checks++; if (bad_pop != 0) begin failures++; $display("FAIL hold_pop got=%0d want=0 pops", bad_pop); end
      checks++; if (bad_data != 0) begin failures++; $display("FAIL hold_stable got=%0d want=0 changes", bad_data); end
      @(posedge clk); #1;
      bus.m_ready = 1'b1;
      wait_words(2, 30, ok);
      checks++; if (!ok) begin failures++; $display("FAIL hold_timeout got=%0d want=2 words", got_data.size()); end
      if (ok) begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i]) begin
               failures++; $display("FAIL hold_word%0d got=%h/%h want=%h/%h", i, got_data[i], got_keep[i], exp_data[i], exp_keep[i]);
            end
         end
         checks++; if (got_cyc[1] - got_cyc[0] != LANES + 1) begin failures++; $display("FAIL throughput got=%0d want=%0d cycles", got_cyc[1] - got_cyc[0], LANES + 1); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int n = 0, occ_bad = 0;
      do_reset();
      while (n < 62) begin
         bus.m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 7) begin push_byte(WIDTH'($urandom)); n++; end
         else idle(1);
         if (occupancy !== CNT_W'(cnt)) occ_bad++;
      end
      checks++; if (occ_bad != 0) begin failures++; $display("FAIL rand_occ got=%0d want=0 mismatching cycles", occ_bad); end
      build_expected(1'b1);
      bus.m_ready = 1'b1; flush = 1'b1;
      wait_words(exp_data.size(), 400, ok);
      flush = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL rand_timeout got=%0d want=%0d words", got_data.size(), exp_data.size()); end
      if (ok) begin
         for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_keep[i] !== exp_keep[i]) begin
               failures++; $display("FAIL rand_word%0d got=%h/%h want=%h/%h", i, got_data[i], got_keep[i], exp_data[i], exp_keep[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      bus.m_ready = 1'b0;
      for (int i = 0; i < DEPTH + LANES + 2; i++) push_byte(WIDTH'(i));
      checks++; if (occupancy !== CNT_W'(DEPTH)) begin failures++; $display("FAIL ovf_occ got=%0d want=%0d", occupancy, DEPTH); end
      checks++; if (overflow !== 1'b1 || overflow !== exp_ovf) begin failures++; $display("FAIL ovf_flag got=%b want=%b", overflow, exp_ovf); end
      idle(5);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
      do_reset();
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", overflow); end
   endtask

   task automatic test_simultaneous();
      logic [CNT_W-1:0] o;
      logic p;
      int pop_cycles = 0;
      do_reset();
      bus.m_ready = 1'b1;
      repeat (3) push_byte(WIDTH'($urandom));
      repeat (10) begin
         push_mon = 1'b1; push_data = WIDTH'($urandom);
         @(negedge clk); o = occupancy; p = pop;
         @(posedge clk); #1;
         checks++;
         if (p) begin
            pop_cycles++;
            if (occupancy !== o) begin failures++; $display("FAIL simul_occ got=%0d want=%0d", occupancy, o); end
         end else if (occupancy !== o + 1'b1) begin
            failures++; $display("FAIL simul_push_occ got=%0d want=%0d", occupancy, o + 1'b1);
         end
      end
      push_mon = 1'b0;
      checks++; if (pop_cycles < 7) begin failures++; $display("FAIL simul_pops got=%0d want>=7", pop_cycles); end
   endtask

   task automatic test_async_reset();
      bit ok;
      do_reset();
      bus.m_ready = 1'b0;
      repeat (6) push_byte(WIDTH'($urandom));
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b want=0", bus.m_valid); end
      checks++; if (bus.m_keep !== '0) begin failures++; $display("FAIL areset_keep got=%h want=0", bus.m_keep); end
      checks++; if (occupancy !== '0) begin failures++; $display("FAIL areset_occ got=%0d want=0", occupancy); end
      checks++; if (pop !== 1'b0) begin failures++; $display("FAIL areset_pop got=%b want=0", pop); end
      @(posedge clk); #1 reset_n = 1'b1;
      clear_queues();
      bus.m_ready = 1'b1;
      repeat (4) push_byte(WIDTH'($urandom));
      build_expected(1'b0);
      wait_words(1, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL areset_timeout got=%0d want=1 words", got_data.size()); end
      else if (got_data[0] !== exp_data[0]) begin failures++; $display("FAIL areset_word got=%h want=%h", got_data[0], exp_data[0]); end
   endtask

`ifdef FIFO_PACK_PARITY_EN
   task automatic test_parity();
      bit ok;
      logic [LANES-1:0] want;
      do_reset();
      bus.m_ready = 1'b1;
      push_byte(8'h00); push_byte(8'h01); push_byte(8'h03); push_byte(8'h07);
      build_expected(1'b0);
      for (int j = 0; j < LANES; j++) want[j] = ^exp_data[0][j*WIDTH +: WIDTH];
      wait_words(1, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL parity_timeout got=%0d want=1 words", got_data.size()); end
      else if (got_data[0] !== 32'h07030100 || got_par[0] !== want) begin
         failures++; $display("FAIL parity got=%h/%b want=07030100/%b", got_data[0], got_par[0], want);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_flush();
      test_hold();
      test_back_to_back();
      test_overflow();
      test_simultaneous();
      test_async_reset();
`ifdef FIFO_PACK_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
